// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared TAP state, opcode and AHB FSM definitions.
// Revision    : 1.0
// ============================================================================
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'h0,
        UPDATE_IR        = 4'h1,
        RUN_TEST_IDLE    = 4'h2,
        SELECT_DR        = 4'h3,
        CAPTURE_DR       = 4'h4,
        SHIFT_DR         = 4'h5,
        EXIT1_DR         = 4'h6,
        PAUSE_DR         = 4'h7,
        EXIT2_DR         = 4'h8,
        UPDATE_DR        = 4'h9,
        SELECT_IR        = 4'hA,
        CAPTURE_IR       = 4'hB,
        SHIFT_IR         = 4'hC,
        EXIT1_IR         = 4'hD,
        PAUSE_IR         = 4'hE,
        EXIT2_IR         = 4'hF
    } tap_state_t;

    localparam int c_OP_IDCODE = 1;
    localparam int c_OP_ADDR   = 2;
    localparam int c_OP_WDATA  = 3;
    localparam int c_OP_RDATA  = 4;
    localparam int c_OP_STATUS = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_PH = 2'd1,
        DATA_PH = 2'd2
    } ahb_state_t;

    typedef enum logic [2:0] {
        DR_BYPASS = 3'd0,
        DR_IDCODE = 3'd1,
        DR_ADDR   = 3'd2,
        DR_WDATA  = 3'd3,
        DR_RDATA  = 3'd4,
        DR_STATUS = 3'd5
    } dr_sel_t;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

endpackage
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_fsm
// Description : IEEE 1149.1 16-state TAP controller driven by TMS.
// Revision    : 1.0
// ============================================================================
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tms,
    output tap_state_t o_state
);

    tap_state_t r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= TEST_LOGIC_RESET;
        end else begin
            case (r_state)
                TEST_LOGIC_RESET: r_state <= i_tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    r_state <= i_tms ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_DR:        r_state <= i_tms ? SELECT_IR : CAPTURE_DR;
                CAPTURE_DR:       r_state <= i_tms ? EXIT1_DR : SHIFT_DR;
                SHIFT_DR:         r_state <= i_tms ? EXIT1_DR : SHIFT_DR;
                EXIT1_DR:         r_state <= i_tms ? UPDATE_DR : PAUSE_DR;
                PAUSE_DR:         r_state <= i_tms ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR:         r_state <= i_tms ? UPDATE_DR : SHIFT_DR;
                UPDATE_DR:        r_state <= i_tms ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_IR:        r_state <= i_tms ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       r_state <= i_tms ? EXIT1_IR : SHIFT_IR;
                SHIFT_IR:         r_state <= i_tms ? EXIT1_IR : SHIFT_IR;
                EXIT1_IR:         r_state <= i_tms ? UPDATE_IR : PAUSE_IR;
                PAUSE_IR:         r_state <= i_tms ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR:         r_state <= i_tms ? UPDATE_IR : SHIFT_IR;
                UPDATE_IR:        r_state <= i_tms ? SELECT_DR : RUN_TEST_IDLE;
                default:          r_state <= TEST_LOGIC_RESET;
            endcase
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/jtag_ahb_dtm.sv
`default_nettype none
// ============================================================================
// Module      : jtag_ahb_dtm
// Description : JTAG TAP with DR mux and AHB-Lite single-transfer master.
// Revision    : 1.0
// ============================================================================
module jtag_ahb_dtm
    import jtag_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] IDCODE_VAL = 32'h0F0F_0F01
) (
    input  logic              TCK,
    input  logic              TRST_N,
    input  logic              TMS,
    input  logic              TDI,
    output logic              TDO,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA
);

    // One shift register serves every DR; it must hold the widest of them.
    localparam int c_DR_W  = (ADDR_W > DATA_W) ? ((ADDR_W > 32) ? ADDR_W : 32)
                                               : ((DATA_W > 32) ? DATA_W : 32);
    localparam int c_IDX_W = $clog2(c_DR_W);
    localparam logic [ADDR_W-1:0] c_STEP = ADDR_W'(DATA_W / 8);

    tap_state_t        w_tap;
    dr_sel_t           w_sel;
    logic              w_rst;
    logic              w_clr;
    logic              w_busy;
    logic              w_update;
    logic [c_DR_W-1:0] w_dr_cap;
    logic [c_DR_W-1:0] w_dr_shift;
    logic [c_IDX_W-1:0] w_dr_msb;

    logic [IR_W-1:0]   r_ir;
    logic [IR_W-1:0]   r_ir_shift;
    logic [c_DR_W-1:0] r_dr;
    logic              r_tdo;
    ahb_state_t        r_ahb;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_haddr;
    logic [DATA_W-1:0] r_hwdata;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_htrans;
    logic              r_hwrite;
    logic              r_op_write;
    logic              r_autoinc;
    logic              r_error;
    logic              r_overrun;

    assign w_rst = ~TRST_N;

    jtag_tap_fsm u_tap (
        .clk     (TCK),
        .rst     (w_rst),
        .i_tms   (TMS),
        .o_state (w_tap)
    );

    // Test-Logic-Reset state acts like the pin reset for everything but the TAP.
    assign w_clr    = w_rst | (w_tap == TEST_LOGIC_RESET);
    assign w_busy   = (r_ahb != IDLE);
    assign w_update = (w_tap == UPDATE_DR);

    always_comb begin
        w_sel = DR_BYPASS;
        if (r_ir == IR_W'(c_OP_IDCODE))      w_sel = DR_IDCODE;
        else if (r_ir == IR_W'(c_OP_ADDR))   w_sel = DR_ADDR;
        else if (r_ir == IR_W'(c_OP_WDATA))  w_sel = DR_WDATA;
        else if (r_ir == IR_W'(c_OP_RDATA))  w_sel = DR_RDATA;
        else if (r_ir == IR_W'(c_OP_STATUS)) w_sel = DR_STATUS;
    end

    always_comb begin
        w_dr_cap = '0;
        w_dr_msb = '0;
        case (w_sel)
            DR_IDCODE: begin
                w_dr_cap = c_DR_W'(IDCODE_VAL);
                w_dr_msb = c_IDX_W'(31);
            end
            DR_ADDR: begin
                w_dr_cap = c_DR_W'(r_addr);
                w_dr_msb = c_IDX_W'(ADDR_W - 1);
            end
            DR_WDATA: begin
                w_dr_msb = c_IDX_W'(DATA_W - 1);
            end
            DR_RDATA: begin
                w_dr_cap = c_DR_W'(r_rdata);
                w_dr_msb = c_IDX_W'(DATA_W - 1);
            end
            DR_STATUS: begin
                w_dr_cap = c_DR_W'({r_overrun, r_error, w_busy, r_autoinc});
                w_dr_msb = c_IDX_W'(3);
            end
            default: ;
        endcase
        w_dr_shift           = r_dr >> 1;
        w_dr_shift[w_dr_msb] = TDI;
    end

    always_ff @(posedge TCK) begin
        if (w_clr) begin
            r_ir       <= IR_W'(c_OP_IDCODE);
            r_ir_shift <= '0;
        end else begin
            case (w_tap)
                CAPTURE_IR: r_ir_shift <= {{(IR_W-2){1'b0}}, 2'b01};
                SHIFT_IR:   r_ir_shift <= {TDI, r_ir_shift[IR_W-1:1]};
                UPDATE_IR:  r_ir       <= r_ir_shift;
                default: ;
            endcase
        end
    end

    always_ff @(posedge TCK) begin
        if (w_clr) begin
            r_dr <= '0;
        end else if (w_tap == CAPTURE_DR) begin
            r_dr <= w_dr_cap;
        end else if (w_tap == SHIFT_DR) begin
            r_dr <= w_dr_shift;
        end
    end

    always_ff @(negedge TCK) begin
        if (w_rst) begin
            r_tdo <= 1'b0;
        end else if (w_tap == SHIFT_IR) begin
            r_tdo <= r_ir_shift[0];
        end else if (w_tap == SHIFT_DR) begin
            r_tdo <= r_dr[0];
        end else begin
            r_tdo <= 1'b0;
        end
    end

    // DR updates come first so that FSM-side status sets override a W1C.
    always_ff @(posedge TCK) begin
        if (w_clr) begin
            r_ahb      <= IDLE;
            r_addr     <= '0;
            r_haddr    <= '0;
            r_hwdata   <= '0;
            r_rdata    <= '0;
            r_htrans   <= c_HTRANS_IDLE;
            r_hwrite   <= 1'b0;
            r_op_write <= 1'b0;
            r_autoinc  <= 1'b0;
            r_error    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_update) begin
                case (w_sel)
                    DR_ADDR: begin
                        if (w_busy) r_overrun <= 1'b1;
                        else        r_addr    <= r_dr[ADDR_W-1:0];
                    end
                    DR_STATUS: begin
                        r_autoinc <= r_dr[0];
                        if (r_dr[2]) r_error   <= 1'b0;
                        if (r_dr[3]) r_overrun <= 1'b0;
                    end
                    default: ;
                endcase
                if (w_sel == DR_WDATA) r_hwdata <= r_dr[DATA_W-1:0];
                if (w_sel == DR_WDATA || w_sel == DR_RDATA) begin
                    if (w_busy) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_htrans   <= c_HTRANS_NONSEQ;
                        r_hwrite   <= (w_sel == DR_WDATA);
                        r_op_write <= (w_sel == DR_WDATA);
                        r_haddr    <= r_addr;
                        r_ahb      <= ADDR_PH;
                    end
                end
            end

            case (r_ahb)
                ADDR_PH: begin
                    if (HREADY) begin
                        r_htrans <= c_HTRANS_IDLE;
                        r_hwrite <= 1'b0;
                        r_ahb    <= DATA_PH;
                    end
                end
                DATA_PH: begin
                    if (HREADY) begin
                        if (!r_op_write) r_rdata <= HRDATA;
                        if (HRESP)          r_error <= 1'b1;
                        else if (r_autoinc) r_addr  <= r_addr + c_STEP;
                        r_ahb <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign TDO    = r_tdo;
    assign HADDR  = r_haddr;
    assign HTRANS = r_htrans;
    assign HWRITE = r_hwrite;
    assign HWDATA = r_hwdata;
    assign HSIZE  = 3'($clog2(DATA_W / 8));

endmodule
`default_nettype wire

// File: tb/tb_jtag_ahb_dtm.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_ahb_dtm
// Description : Directed table-driven bench for jtag_ahb_dtm.
// Revision    : 1.0
// ============================================================================
module tb_jtag_ahb_dtm;

    logic        TCK;
    logic        TRST_N;
    logic        TMS;
    logic        TDI;
    logic        TDO;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [3:0]  ir;
        int          len;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    jtag_ahb_dtm dut (
        .TCK    (TCK),
        .TRST_N (TRST_N),
        .TMS    (TMS),
        .TDI    (TDI),
        .TDO    (TDO),
        .HREADY (HREADY),
        .HRESP  (HRESP),
        .HRDATA (HRDATA),
        .HADDR  (HADDR),
        .HTRANS (HTRANS),
        .HWRITE (HWRITE),
        .HSIZE  (HSIZE),
        .HWDATA (HWDATA)
    );

    initial begin
        TCK = 1'b0;
        forever #5 TCK = ~TCK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns TDO as presented before the rising edge that consumes tms/tdi.
    task automatic step(input logic tms, input logic tdi, output logic tdo_o);
        tdo_o = TDO;
        TMS   = tms;
        TDI   = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    task automatic idle(input int n);
        logic b;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, b);
    endtask

    task automatic scan_ir(input logic [3:0] ir, output logic [3:0] cap);
        logic b;
        cap = '0;
        step(1'b1, 1'b0, b);
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b0, b);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, ir[i], b);
            cap[i] = b;
        end
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
    endtask

    task automatic scan_dr(input int len, input logic [31:0] din, output logic [31:0] dout);
        logic b;
        dout = '0;
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
        step(1'b0, 1'b0, b);
        for (int i = 0; i < len; i++) begin
            step(i == len - 1, din[i], b);
            dout[i] = b;
        end
        step(1'b1, 1'b0, b);
        step(1'b0, 1'b0, b);
    endtask

    task automatic ir_chk(input logic [3:0] ir);
        logic [3:0] cap;
        scan_ir(ir, cap);
        check("ir_capture", 32'(cap), 32'h1);
    endtask

    task automatic dr_chk(input string name, input int len, input logic [31:0] din,
                          input logic [31:0] exp);
        logic [31:0] dout;
        scan_dr(len, din, dout);
        check(name, dout, exp);
    endtask

    initial begin
        logic b;
        n_cmp = 0;
        n_err = 0;

        vecs[0]  = '{ir: 4'h1, len: 32, din: 32'h0,        exp: 32'h0F0F_0F01};
        vecs[1]  = '{ir: 4'h2, len: 32, din: 32'h40,       exp: 32'h0};
        vecs[2]  = '{ir: 4'h2, len: 32, din: 32'h80,       exp: 32'h40};
        vecs[3]  = '{ir: 4'h4, len: 32, din: 32'h0,        exp: 32'h0};
        vecs[4]  = '{ir: 4'h4, len: 32, din: 32'h0,        exp: 32'h1234_5678};
        vecs[5]  = '{ir: 4'h5, len: 4,  din: 32'h1,        exp: 32'h0};
        vecs[6]  = '{ir: 4'h5, len: 4,  din: 32'h0,        exp: 32'h1};
        vecs[7]  = '{ir: 4'h3, len: 32, din: 32'hA5A5_A5A5, exp: 32'h0};
        vecs[8]  = '{ir: 4'hF, len: 9,  din: 32'h0B5,      exp: 32'h16A};
        vecs[9]  = '{ir: 4'h7, len: 9,  din: 32'h153,      exp: 32'h0A6};
        vecs[10] = '{ir: 4'h2, len: 32, din: 32'h80,       exp: 32'h80};
        vecs[11] = '{ir: 4'h5, len: 4,  din: 32'h0,        exp: 32'h0};

        TRST_N = 1'b0;
        TMS    = 1'b1;
        TDI    = 1'b0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h1234_5678;
        @(negedge TCK);
        #1;

        // Reset state
        step(1'b1, 1'b0, b);
        TRST_N = 1'b1;
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwrite", 32'(HWRITE), 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_tdo", 32'(TDO), 32'h0);
        check("hsize", 32'(HSIZE), 32'h2);
        step(1'b0, 1'b0, b);

        // IDCODE selected by reset, no IR scan needed
        dr_chk("t1_idcode", 32, 32'h0, 32'h0F0F_0F01);

        for (int i = 0; i < 12; i++) begin
            ir_chk(vecs[i].ir);
            dr_chk($sformatf("vec%0d", i), vecs[i].len, vecs[i].din, vecs[i].exp);
            idle(4);
        end
        check("vec_hwdata", HWDATA, 32'hA5A5_A5A5);

        // Write with two address-phase wait states
        ir_chk(4'h2);
        dr_chk("t3_addr", 32, 32'h1000, 32'h80);
        HREADY = 1'b0;
        ir_chk(4'h3);
        dr_chk("t3_wdata", 32, 32'hDEAD_BEEF, 32'h0);
        check("t3_htrans0", 32'(HTRANS), 32'h2);
        check("t3_haddr", HADDR, 32'h1000);
        check("t3_hwrite", 32'(HWRITE), 32'h1);
        check("t3_hwdata", HWDATA, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, b);
        check("t3_htrans1", 32'(HTRANS), 32'h2);
        step(1'b0, 1'b0, b);
        check("t3_htrans2", 32'(HTRANS), 32'h2);
        HREADY = 1'b1;
        step(1'b0, 1'b0, b);
        check("t3_htrans3", 32'(HTRANS), 32'h0);
        check("t3_hwrite3", 32'(HWRITE), 32'h0);
        step(1'b0, 1'b0, b);
        ir_chk(4'h5);
        dr_chk("t3_status", 4, 32'h0, 32'h0);

        // Pipelined read
        HRDATA = 32'hCAFE_F00D;
        ir_chk(4'h4);
        dr_chk("t4_rd1", 32, 32'h0, 32'h1234_5678);
        idle(4);
        dr_chk("t4_rd2", 32, 32'h0, 32'hCAFE_F00D);
        idle(4);

        // Auto-increment across the top of the address space
        ir_chk(4'h5);
        dr_chk("t5_status", 4, 32'h1, 32'h0);
        ir_chk(4'h2);
        dr_chk("t5_addr", 32, 32'hFFFF_FFFC, 32'h1000);
        ir_chk(4'h3);
        dr_chk("t5_wr1", 32, 32'h1111_1111, 32'h0);
        check("t5_haddr1", HADDR, 32'hFFFF_FFFC);
        idle(4);
        dr_chk("t5_wr2", 32, 32'h2222_2222, 32'h0);
        check("t5_haddr2", HADDR, 32'h0);
        idle(4);
        ir_chk(4'h2);
        dr_chk("t5_addr_cap", 32, 32'h2000, 32'h4);

        // Error response, overrun, W1C and TMS reset mid-transfer
        HRESP = 1'b1;
        ir_chk(4'h3);
        dr_chk("t6_wr_err", 32, 32'h3333_3333, 32'h0);
        idle(4);
        HRESP = 1'b0;
        ir_chk(4'h5);
        dr_chk("t6_status_err", 4, 32'h1, 32'h5);
        ir_chk(4'h2);
        dr_chk("t6_addr_noinc", 32, 32'h2000, 32'h2000);
        HREADY = 1'b0;
        ir_chk(4'h3);
        dr_chk("t6_wr_busy", 32, 32'h4444_4444, 32'h0);
        dr_chk("t6_wr_overrun", 32, 32'h5555_5555, 32'h0);
        check("t6_hwdata", HWDATA, 32'h5555_5555);
        check("t6_haddr", HADDR, 32'h2000);
        check("t6_htrans_busy", 32'(HTRANS), 32'h2);
        ir_chk(4'h5);
        dr_chk("t6_status_all", 4, 32'hC, 32'hF);
        dr_chk("t6_status_w1c", 4, 32'h0, 32'h2);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, b);
        check("t6_tlr_htrans", 32'(HTRANS), 32'h0);
        check("t6_tlr_hwdata", HWDATA, 32'h0);
        step(1'b0, 1'b0, b);
        ir_chk(4'h5);
        dr_chk("t6_status_tlr", 4, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
